// File: rtl/pcie_tx_sched_pkg.sv
// Shared types and default periods for the PCIe TX ordered-set scheduler.
package pcie_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDL   = 3'd0,
        TS1   = 3'd1,
        TS2   = 3'd2,
        FTS   = 3'd3,
        SKP   = 3'd4,
        EIEOS = 3'd5,
        EIOS  = 3'd6,
        DATA  = 3'd7
    } os_type_e;

    typedef enum logic [1:0] {
        StActive = 2'd0,
        StData   = 2'd1,
        StEidle  = 2'd2
    } sched_state_e;

    localparam int unsigned SKP_PERIOD_G12_DEF = 295;
    localparam int unsigned SKP_PERIOD_G34_DEF = 370;
    localparam int unsigned EIEOS_PERIOD_DEF   = 32;

endpackage

// File: rtl/pcie_tx_os_scheduler_if.sv
// Request/slot bus between the LTSSM-side requesters, the serializer and the scheduler.
interface pcie_tx_os_scheduler_if;
    import pcie_tx_sched_pkg::*;

    logic        rate_gen34;
    logic        in_l0;
    logic        slot_rdy;
    logic        ts_req;
    logic        ts_type;
    logic [15:0] ts_num;
    logic        fts_req;
    logic [7:0]  n_fts;
    logic        eios_req;
    logic        data_req;
    logic        data_last;

    logic        os_valid;
    os_type_e    os_type;
    logic        ts_done;
    logic        fts_done;
    logic        eios_done;
    logic [15:0] ts_sent_cnt;
    logic [1:0]  skp_pending;
    logic        elec_idle;

    modport master (
        output rate_gen34, in_l0, slot_rdy, ts_req, ts_type, ts_num, fts_req, n_fts,
               eios_req, data_req, data_last,
        input  os_valid, os_type, ts_done, fts_done, eios_done, ts_sent_cnt, skp_pending,
               elec_idle
    );

    modport slave (
        input  rate_gen34, in_l0, slot_rdy, ts_req, ts_type, ts_num, fts_req, n_fts,
               eios_req, data_req, data_last,
        output os_valid, os_type, ts_done, fts_done, eios_done, ts_sent_cnt, skp_pending,
               elec_idle
    );

endinterface

// File: rtl/pcie_skp_period_timer.sv
// SKP interval timer: rate/L0 period select, slot counter and saturating pending count.
module pcie_skp_period_timer #(
    parameter int unsigned SKP_PERIOD_G12_L0  = 295,
    parameter int unsigned SKP_PERIOD_G12_NL0 = 295,
    parameter int unsigned SKP_PERIOD_G34_L0  = 370,
    parameter int unsigned SKP_PERIOD_G34_NL0 = 370
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rate_gen34_i,
    input  logic       in_l0_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       dec_i,
    output logic [1:0] pending_o
);

    logic [15:0] cnt_q, cnt_d, last_slot;
    logic [1:0]  pend_q, pend_d;
    logic        wrap;

    always_comb begin
        unique case ({rate_gen34_i, in_l0_i})
            2'b00: last_slot = 16'(SKP_PERIOD_G12_NL0 - 1);
            2'b01: last_slot = 16'(SKP_PERIOD_G12_L0 - 1);
            2'b10: last_slot = 16'(SKP_PERIOD_G34_NL0 - 1);
            2'b11: last_slot = 16'(SKP_PERIOD_G34_L0 - 1);
        endcase

        // >= keeps the wrap safe when in_l0 shortens the period mid-count
        wrap  = en_i && (cnt_q >= last_slot);
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
        end

        pend_d = pend_q;
        if (wrap && !dec_i && (pend_q != 2'd3)) begin
            pend_d = pend_q + 2'd1;
        end else if (!wrap && dec_i && (pend_q != 2'd0)) begin
            pend_d = pend_q - 2'd1;
        end

        if (clr_i) begin
            cnt_d  = 16'd0;
            pend_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 16'd0;
            pend_q <= 2'd0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/pcie_tx_os_scheduler.sv
// Per-slot ordered-set arbiter for the PCIe TX path; picks one OS per slot_rdy and
// inserts SKP/EIEOS on their periods.
module pcie_tx_os_scheduler
    import pcie_tx_sched_pkg::*;
#(
    parameter int unsigned SKP_PERIOD_G12_L0  = SKP_PERIOD_G12_DEF,
    parameter int unsigned SKP_PERIOD_G12_NL0 = SKP_PERIOD_G12_DEF,
    parameter int unsigned SKP_PERIOD_G34_L0  = SKP_PERIOD_G34_DEF,
    parameter int unsigned SKP_PERIOD_G34_NL0 = SKP_PERIOD_G34_DEF,
    parameter int unsigned EIEOS_PERIOD       = EIEOS_PERIOD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pcie_tx_os_scheduler_if.slave bus
);

    localparam logic [15:0] EIEOS_LAST = 16'(EIEOS_PERIOD);

    sched_state_e state_q, state_d;
    logic        ts_active_q, ts_active_d, fts_active_q, fts_active_d;
    logic [15:0] ts_left_q, ts_left_d, ts_sent_q, ts_sent_d;
    logic        ts_kind_q, ts_kind_d;
    logic [7:0]  fts_left_q, fts_left_d;
    logic [15:0] eieos_cnt_q, eieos_cnt_d;
    logic        eieos_due_q, eieos_due_d;
    logic        rate_q;
    logic        os_valid_q, os_valid_d, elec_idle_q, elec_idle_d;
    os_type_e    os_type_q, os_type_d;
    logic        ts_done_q, ts_done_d, fts_done_q, fts_done_d, eios_done_q, eios_done_d;

    logic        acc_ts, acc_fts, cur_ts_act, cur_fts_act, cur_due, cur_ts_kind;
    logic [15:0] cur_ts_left, cur_ts_sent, cur_ecnt;
    logic [7:0]  cur_fts_left;
    logic        skp_en, skp_clr, skp_dec;
    logic [1:0]  skp_pending;

    pcie_skp_period_timer #(
        .SKP_PERIOD_G12_L0  (SKP_PERIOD_G12_L0),
        .SKP_PERIOD_G12_NL0 (SKP_PERIOD_G12_NL0),
        .SKP_PERIOD_G34_L0  (SKP_PERIOD_G34_L0),
        .SKP_PERIOD_G34_NL0 (SKP_PERIOD_G34_NL0)
    ) u_skp_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .rate_gen34_i (bus.rate_gen34),
        .in_l0_i      (bus.in_l0),
        .en_i         (skp_en),
        .clr_i        (skp_clr),
        .dec_i        (skp_dec),
        .pending_o    (skp_pending)
    );

    assign skp_en = bus.slot_rdy && (state_q != StEidle);

    always_comb begin
        state_d      = state_q;
        ts_active_d  = ts_active_q;
        ts_left_d    = ts_left_q;
        ts_sent_d    = ts_sent_q;
        ts_kind_d    = ts_kind_q;
        fts_active_d = fts_active_q;
        fts_left_d   = fts_left_q;
        eieos_cnt_d  = eieos_cnt_q;
        eieos_due_d  = eieos_due_q;
        elec_idle_d  = elec_idle_q;
        os_valid_d   = 1'b0;
        os_type_d    = IDL;
        ts_done_d    = 1'b0;
        fts_done_d   = 1'b0;
        eios_done_d  = 1'b0;
        skp_dec      = 1'b0;
        skp_clr      = (bus.rate_gen34 != rate_q);

        // An accepted burst is visible to the arbitration of its own acceptance slot
        acc_ts       = bus.slot_rdy && bus.ts_req && !ts_active_q;
        acc_fts      = bus.slot_rdy && bus.fts_req && !fts_active_q;
        cur_ts_act   = ts_active_q || (acc_ts && (bus.ts_num != 16'd0));
        cur_fts_act  = fts_active_q || (acc_fts && (bus.n_fts != 8'd0));
        cur_ts_left  = acc_ts ? bus.ts_num : ts_left_q;
        cur_ts_sent  = acc_ts ? 16'd0 : ts_sent_q;
        cur_ts_kind  = acc_ts ? bus.ts_type : ts_kind_q;
        cur_fts_left = acc_fts ? bus.n_fts : fts_left_q;
        cur_ecnt     = acc_ts ? 16'd0 : eieos_cnt_q;
        cur_due      = bus.rate_gen34 && (eieos_due_q || (acc_ts && (bus.ts_num != 16'd0)));

        if (bus.slot_rdy) begin
            ts_active_d  = cur_ts_act;
            ts_left_d    = cur_ts_left;
            ts_sent_d    = cur_ts_sent;
            ts_kind_d    = cur_ts_kind;
            fts_active_d = cur_fts_act;
            fts_left_d   = cur_fts_left;
            eieos_cnt_d  = cur_ecnt;
            eieos_due_d  = cur_due;
            ts_done_d    = acc_ts && (bus.ts_num == 16'd0);
            fts_done_d   = acc_fts && (bus.n_fts == 8'd0);

            if (state_q == StData) begin
                os_valid_d = 1'b1;
                if (bus.data_req) begin
                    os_type_d = DATA;
                    if (bus.data_last) begin
                        state_d = StActive;
                    end
                end
            end else if ((state_q != StEidle) || bus.ts_req || bus.fts_req) begin
                os_valid_d  = 1'b1;
                elec_idle_d = 1'b0;
                state_d     = StActive;
                if (bus.eios_req) begin
                    // Electrical idle abandons any burst in flight
                    os_type_d    = EIOS;
                    eios_done_d  = 1'b1;
                    elec_idle_d  = 1'b1;
                    state_d      = StEidle;
                    skp_clr      = 1'b1;
                    ts_active_d  = 1'b0;
                    fts_active_d = 1'b0;
                end else if (skp_pending != 2'd0) begin
                    os_type_d = SKP;
                    skp_dec   = 1'b1;
                end else if (cur_due && cur_ts_act) begin
                    os_type_d   = EIEOS;
                    eieos_due_d = 1'b0;
                end else if (cur_fts_act) begin
                    os_type_d  = FTS;
                    fts_left_d = cur_fts_left - 8'd1;
                    if (cur_fts_left == 8'd1) begin
                        fts_active_d = 1'b0;
                        fts_done_d   = 1'b1;
                    end
                end else if (cur_ts_act) begin
                    os_type_d   = cur_ts_kind ? TS2 : TS1;
                    ts_left_d   = cur_ts_left - 16'd1;
                    ts_sent_d   = cur_ts_sent + 16'd1;
                    eieos_cnt_d = cur_ecnt + 16'd1;
                    if (cur_ecnt + 16'd1 == EIEOS_LAST) begin
                        eieos_cnt_d = 16'd0;
                        eieos_due_d = 1'b1;
                    end
                    if (cur_ts_left == 16'd1) begin
                        ts_active_d = 1'b0;
                        ts_done_d   = 1'b1;
                    end
                end else if (bus.data_req) begin
                    os_type_d = DATA;
                    if (!bus.data_last) begin
                        state_d = StData;
                    end
                end
            end
        end

        if (!bus.rate_gen34) begin
            eieos_due_d = 1'b0;
            eieos_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StActive;
            ts_active_q  <= 1'b0;
            ts_left_q    <= 16'd0;
            ts_sent_q    <= 16'd0;
            ts_kind_q    <= 1'b0;
            fts_active_q <= 1'b0;
            fts_left_q   <= 8'd0;
            eieos_cnt_q  <= 16'd0;
            eieos_due_q  <= 1'b0;
            rate_q       <= 1'b0;
            os_valid_q   <= 1'b0;
            os_type_q    <= IDL;
            ts_done_q    <= 1'b0;
            fts_done_q   <= 1'b0;
            eios_done_q  <= 1'b0;
            elec_idle_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ts_active_q  <= ts_active_d;
            ts_left_q    <= ts_left_d;
            ts_sent_q    <= ts_sent_d;
            ts_kind_q    <= ts_kind_d;
            fts_active_q <= fts_active_d;
            fts_left_q   <= fts_left_d;
            eieos_cnt_q  <= eieos_cnt_d;
            eieos_due_q  <= eieos_due_d;
            rate_q       <= bus.rate_gen34;
            os_valid_q   <= os_valid_d;
            os_type_q    <= os_type_d;
            ts_done_q    <= ts_done_d;
            fts_done_q   <= fts_done_d;
            eios_done_q  <= eios_done_d;
            elec_idle_q  <= elec_idle_d;
        end
    end

    assign bus.os_valid    = os_valid_q;
    assign bus.os_type     = os_type_q;
    assign bus.ts_done     = ts_done_q;
    assign bus.fts_done    = fts_done_q;
    assign bus.eios_done   = eios_done_q;
    assign bus.ts_sent_cnt = ts_sent_q;
    assign bus.skp_pending = skp_pending;
    assign bus.elec_idle   = elec_idle_q;

endmodule

// File: tb/tb_pcie_tx_os_scheduler.sv
// Bench for pcie_tx_os_scheduler: directed scenarios plus a randomized phase, each slot
// compared against a remaining-count reference model.
module tb_pcie_tx_os_scheduler;
    import pcie_tx_sched_pkg::*;

    localparam int P_G12_L0  = 295;
    localparam int P_G12_NL0 = 180;
    localparam int P_G34_L0  = 370;
    localparam int P_G34_NL0 = 250;
    localparam int P_EIE     = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    pcie_tx_os_scheduler_if bus_if ();

    pcie_tx_os_scheduler #(
        .SKP_PERIOD_G12_L0  (P_G12_L0),
        .SKP_PERIOD_G12_NL0 (P_G12_NL0),
        .SKP_PERIOD_G34_L0  (P_G34_L0),
        .SKP_PERIOD_G34_NL0 (P_G34_NL0),
        .EIEOS_PERIOD       (P_EIE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: link mode 0=active 1=in packet 2=electrical idle
    int m_mode, m_ts_left, m_ts_sent, m_ts_kind, m_fts_left;
    int m_skp_slots, m_skp_pend, m_since, m_owed, m_rate;
    logic     e_valid, e_tsd, e_ftsd, e_eiosd;
    os_type_e e_type;
    int       n_seen [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ts_left = 0; m_ts_sent = 0; m_ts_kind = 0; m_fts_left = 0;
        m_skp_slots = 0; m_skp_pend = 0; m_since = 0; m_owed = 0; m_rate = 0;
        e_valid = 0; e_type = IDL; e_tsd = 0; e_ftsd = 0; e_eiosd = 0;
    endtask

    task automatic clear_seen();
        foreach (n_seen[k]) n_seen[k] = 0;
    endtask

    task automatic model_slot();
        int period;
        bit counted, wrapped, took_skp;
        e_valid = 0; e_type = IDL; e_tsd = 0; e_ftsd = 0; e_eiosd = 0;
        counted = (m_mode != 2);
        wrapped = 0;
        took_skp = 0;
        if (bus_if.rate_gen34) period = bus_if.in_l0 ? P_G34_L0 : P_G34_NL0;
        else                   period = bus_if.in_l0 ? P_G12_L0 : P_G12_NL0;

        if (bus_if.ts_req && m_ts_left == 0) begin
            m_ts_kind = int'(bus_if.ts_type);
            m_ts_left = int'(bus_if.ts_num);
            m_ts_sent = 0;
            m_since   = 0;
            if (bus_if.ts_num == 0) e_tsd = 1;
            else if (bus_if.rate_gen34) m_owed = 1;
        end
        if (bus_if.fts_req && m_fts_left == 0) begin
            m_fts_left = int'(bus_if.n_fts);
            if (bus_if.n_fts == 0) e_ftsd = 1;
        end

        if (m_mode == 1) begin
            e_valid = 1;
            if (bus_if.data_req) begin
                e_type = DATA;
                if (bus_if.data_last) m_mode = 0;
            end
        end else if (m_mode != 2 || bus_if.ts_req || bus_if.fts_req) begin
            e_valid = 1;
            m_mode  = 0;
            if (bus_if.eios_req) begin
                e_type = EIOS; e_eiosd = 1; m_mode = 2; m_ts_left = 0; m_fts_left = 0;
            end else if (m_skp_pend > 0) begin
                e_type = SKP; took_skp = 1;
            end else if (bus_if.rate_gen34 && m_owed != 0 && m_ts_left > 0) begin
                e_type = EIEOS; m_owed = 0;
            end else if (m_fts_left > 0) begin
                e_type = FTS;
                m_fts_left--;
                if (m_fts_left == 0) e_ftsd = 1;
            end else if (m_ts_left > 0) begin
                e_type = (m_ts_kind != 0) ? TS2 : TS1;
                m_ts_left--;
                m_ts_sent++;
                if (m_ts_left == 0) e_tsd = 1;
                if (bus_if.rate_gen34) begin
                    m_since++;
                    if (m_since == P_EIE) begin m_since = 0; m_owed = 1; end
                end
            end else if (bus_if.data_req) begin
                e_type = DATA;
                if (!bus_if.data_last) m_mode = 1;
            end
        end

        if (counted) begin
            if (m_skp_slots + 1 >= period) begin m_skp_slots = 0; wrapped = 1; end
            else m_skp_slots++;
        end
        if (wrapped && !took_skp && m_skp_pend < 3) m_skp_pend++;
        else if (!wrapped && took_skp) m_skp_pend--;
        if (e_eiosd) begin m_skp_slots = 0; m_skp_pend = 0; end
        if (!bus_if.rate_gen34) begin m_owed = 0; m_since = 0; end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".os_valid"},    32'(bus_if.os_valid),    32'(e_valid));
        chk({tag, ".os_type"},     32'(bus_if.os_type),     32'(e_type));
        chk({tag, ".ts_done"},     32'(bus_if.ts_done),     32'(e_tsd));
        chk({tag, ".fts_done"},    32'(bus_if.fts_done),    32'(e_ftsd));
        chk({tag, ".eios_done"},   32'(bus_if.eios_done),   32'(e_eiosd));
        chk({tag, ".ts_sent_cnt"}, 32'(bus_if.ts_sent_cnt), 32'(m_ts_sent));
        chk({tag, ".skp_pending"}, 32'(bus_if.skp_pending), 32'(m_skp_pend));
        chk({tag, ".elec_idle"},   32'(bus_if.elec_idle),   32'(m_mode == 2));
    endtask

    task automatic do_slot(input string tag);
        model_slot();
        bus_if.slot_rdy = 1'b1;
        @(posedge clk); #1;
        bus_if.slot_rdy = 1'b0;
        check_outputs(tag);
        if (bus_if.os_valid === 1'b1) n_seen[int'(bus_if.os_type)]++;
        // Requester side: drop requests once the model says they completed
        if (e_tsd) bus_if.ts_req = 1'b0;
        if (e_ftsd) bus_if.fts_req = 1'b0;
        if (e_eiosd) begin
            bus_if.eios_req = 1'b0; bus_if.ts_req = 1'b0; bus_if.fts_req = 1'b0;
        end
    endtask

    task automatic idle_cycle(input string tag);
        e_valid = 0; e_type = IDL; e_tsd = 0; e_ftsd = 0; e_eiosd = 0;
        @(posedge clk); #1;
        check_outputs(tag);
    endtask

    task automatic set_rate(input logic r);
        bus_if.rate_gen34 = r;
        if (int'(r) != m_rate) begin
            m_rate = int'(r); m_skp_slots = 0; m_skp_pend = 0;
            if (!r) begin m_owed = 0; m_since = 0; end
        end
        idle_cycle("rate_change");
    endtask

    task automatic drive_idle_inputs();
        bus_if.slot_rdy = 0; bus_if.ts_req = 0; bus_if.ts_type = 0; bus_if.ts_num = 0;
        bus_if.fts_req = 0; bus_if.n_fts = 0; bus_if.eios_req = 0; bus_if.data_req = 0;
        bus_if.data_last = 0; bus_if.rate_gen34 = 0; bus_if.in_l0 = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle_inputs();
        model_reset();
        clear_seen();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;
        idle_cycle("post_reset");

        // Gen1/2 TS1 burst of 16
        bus_if.ts_req = 1; bus_if.ts_type = 0; bus_if.ts_num = 16;
        clear_seen();
        for (int i = 0; i < 16; i++) do_slot("ts16");
        chk("ts16.sent_cnt", 32'(bus_if.ts_sent_cnt), 32'd16);
        chk("ts16.n_ts1", n_seen[TS1], 32'd16);
        chk("ts16.n_eieos", n_seen[EIEOS], 32'd0);
        for (int i = 0; i < 2; i++) do_slot("ts16_tail");

        // Gen3/4 TS2 burst of 70 with random gaps
        set_rate(1'b1);
        bus_if.ts_req = 1; bus_if.ts_type = 1; bus_if.ts_num = 70;
        clear_seen();
        for (int i = 0; i < 73; i++) begin
            if ($urandom_range(0, 2) == 0) idle_cycle("ts70_gap");
            do_slot("ts70");
        end
        chk("ts70.n_ts2", n_seen[TS2], 32'd70);
        chk("ts70.n_eieos", n_seen[EIEOS], 32'd3);
        chk("ts70.sent_cnt", 32'(bus_if.ts_sent_cnt), 32'd70);

        // Gen1/2 L0 streaming data, data_last every 400 slots
        set_rate(1'b0);
        bus_if.in_l0 = 1; bus_if.data_req = 1;
        clear_seen();
        for (int i = 0; i < 800; i++) begin
            bus_if.data_last = ((i % 400) == 399);
            do_slot("data400");
        end
        chk("data400.n_skp", n_seen[SKP], 32'd1);
        chk("data400.pending", 32'(bus_if.skp_pending), 32'd1);
        bus_if.data_last = 0;
        do_slot("data400_skp");
        chk("data400.skp_after", 32'(bus_if.os_type), 32'(SKP));
        chk("data400.pending_end", 32'(bus_if.skp_pending), 32'd0);

        // Long packet: pending saturates, then three SKP back to back
        for (int i = 0; i < 1200; i++) do_slot("long_pkt");
        chk("long.pending_sat", 32'(bus_if.skp_pending), 32'd3);
        bus_if.data_last = 1;
        do_slot("long_last");
        bus_if.data_last = 0;
        clear_seen();
        for (int i = 0; i < 3; i++) do_slot("long_skp");
        chk("long.n_skp", n_seen[SKP], 32'd3);
        chk("long.pending_end", 32'(bus_if.skp_pending), 32'd0);

        // EIOS interrupting an FTS burst, then TS1 leaves electrical idle
        bus_if.data_req = 0;
        bus_if.fts_req = 1; bus_if.n_fts = 8;
        for (int i = 0; i < 3; i++) do_slot("fts");
        bus_if.eios_req = 1;
        do_slot("eios");
        chk("eios.type", 32'(bus_if.os_type), 32'(EIOS));
        for (int i = 0; i < 4; i++) do_slot("eidle");
        chk("eidle.elec_idle", 32'(bus_if.elec_idle), 32'd1);
        bus_if.ts_req = 1; bus_if.ts_type = 0; bus_if.ts_num = 4;
        do_slot("eidle_exit");
        chk("exit.type", 32'(bus_if.os_type), 32'(TS1));
        for (int i = 0; i < 4; i++) do_slot("exit_tail");

        // Reset in the middle of a TS2 burst
        bus_if.ts_req = 1; bus_if.ts_type = 1; bus_if.ts_num = 20;
        for (int i = 0; i < 5; i++) do_slot("pre_rst");
        rst_n = 1'b0;
        bus_if.ts_req = 0;
        #2;
        model_reset();
        check_outputs("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) do_slot("post_rst");

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if (!bus_if.ts_req && $urandom_range(0, 9) == 0) begin
                bus_if.ts_req = 1; bus_if.ts_type = 1'($urandom);
                bus_if.ts_num = 16'($urandom_range(0, 40));
            end
            if (!bus_if.fts_req && $urandom_range(0, 11) == 0) begin
                bus_if.fts_req = 1; bus_if.n_fts = 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 79) == 0) bus_if.eios_req = 1;
            bus_if.data_req  = 1'($urandom_range(0, 1));
            bus_if.data_last = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) bus_if.in_l0 = ~bus_if.in_l0;
            if ($urandom_range(0, 149) == 0) set_rate(~bus_if.rate_gen34);
            if ($urandom_range(0, 3) == 0) idle_cycle("rand_gap");
            do_slot("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
